// File: rtl/des_round_ctrl_if.sv
// Handshake and control bus between the DES round sequencer and its datapath/key schedule.
// Adds the abort input when DES_ROUND_CTRL_ABORT_EN is defined.
interface des_round_ctrl_if;
  logic       start;
  logic       decrypt;
`ifdef DES_ROUND_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       busy;
  logic       done;
  logic       ld_data;
  logic       ld_key;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       last_round;
  logic       out_en;

`ifdef DES_ROUND_CTRL_ABORT_EN
  modport master (output start, decrypt, abort,
                  input  busy, done, ld_data, ld_key, round_en, round_idx,
                         key_shift, key_dir, last_round, out_en);
  modport slave  (input  start, decrypt, abort,
                  output busy, done, ld_data, ld_key, round_en, round_idx,
                         key_shift, key_dir, last_round, out_en);
`else
  modport master (output start, decrypt,
                  input  busy, done, ld_data, ld_key, round_en, round_idx,
                         key_shift, key_dir, last_round, out_en);
  modport slave  (input  start, decrypt,
                  output busy, done, ld_data, ld_key, round_en, round_idx,
                         key_shift, key_dir, last_round, out_en);
`endif
endinterface

// File: rtl/des_round_ctrl.sv
// DES round sequencer: IDLE -> LOAD -> ROUND x NUM_ROUNDS -> FINAL -> DONE, all outputs registered.
// Optional feature macro: DES_ROUND_CTRL_ABORT_EN (adds abort input on the interface).
module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input logic            clk,
  input logic            rst_n,
  des_round_ctrl_if.slave bus
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 16) begin : g_bad_rounds
    $error("des_round_ctrl: NUM_ROUNDS must be 1..16");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t     state_q;
  logic       dec_q;
  logic       busy_q, done_q, ld_q, round_en_q, last_q, out_en_q;
  logic [3:0] idx_q;
  logic [1:0] shift_q;
  logic [3:0] nxt_idx;
  logic       abort_hit;

  // Decrypt walks the schedule backwards: no rotate before round 0.
  function automatic logic [1:0] shift_of(input logic [3:0] idx, input logic dec);
    if (idx == 4'd0) return dec ? 2'd0 : 2'd1;
    if (idx == 4'd1 || idx == 4'd8 || idx == 4'd15) return 2'd1;
    return 2'd2;
  endfunction

  assign nxt_idx = idx_q + 4'd1;

`ifdef DES_ROUND_CTRL_ABORT_EN
  assign abort_hit = bus.abort && (state_q == LOAD || state_q == ROUND || state_q == FINAL);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dec_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_q       <= 1'b0;
      round_en_q <= 1'b0;
      last_q     <= 1'b0;
      out_en_q   <= 1'b0;
      idx_q      <= 4'd0;
      shift_q    <= 2'd0;
    end else begin
      ld_q       <= 1'b0;
      round_en_q <= 1'b0;
      last_q     <= 1'b0;
      out_en_q   <= 1'b0;
      done_q     <= 1'b0;
      if (abort_hit) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        idx_q   <= 4'd0;
        shift_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            state_q <= LOAD;
            dec_q   <= bus.decrypt;
            busy_q  <= 1'b1;
            ld_q    <= 1'b1;
            idx_q   <= 4'd0;
            shift_q <= 2'd0;
          end
          LOAD: begin
            state_q    <= ROUND;
            round_en_q <= 1'b1;
            idx_q      <= 4'd0;
            shift_q    <= shift_of(4'd0, dec_q);
            last_q     <= (LAST_IDX == 4'd0);
          end
          ROUND: begin
            if (idx_q == LAST_IDX) begin
              state_q  <= FINAL;
              out_en_q <= 1'b1;
              idx_q    <= 4'd0;
              shift_q  <= 2'd0;
            end else begin
              round_en_q <= 1'b1;
              idx_q      <= nxt_idx;
              shift_q    <= shift_of(nxt_idx, dec_q);
              last_q     <= (nxt_idx == LAST_IDX);
            end
          end
          FINAL: begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ld_data    = ld_q;
  assign bus.ld_key     = ld_q;
  assign bus.round_en   = round_en_q;
  assign bus.round_idx  = idx_q;
  assign bus.key_shift  = shift_q;
  assign bus.key_dir    = dec_q;
  assign bus.last_round = last_q;
  assign bus.out_en     = out_en_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed table-driven bench for des_round_ctrl (default and NUM_ROUNDS=1 instances).
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_round_ctrl_if bus ();
  des_round_ctrl_if bus1 ();

  des_round_ctrl #(.NUM_ROUNDS(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  des_round_ctrl #(.NUM_ROUNDS(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct packed {
    logic       busy, done, ld_data, ld_key, round_en;
    logic [3:0] idx;
    logic [1:0] sh;
    logic       dir, last, out_en;
  } outs_t;

  typedef struct {
    logic  start;
    logic  dec;
    outs_t exp;
  } vec_t;

  localparam logic [1:0] ENC_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [1:0] DEC_SH [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  vec_t vq[$];
  bit   prev_dir;
  int   tests = 0;
  int   errors = 0;

  function automatic outs_t mk(bit b, bit d, bit l, bit r, logic [3:0] i, logic [1:0] s,
                               bit k, bit la, bit o);
    outs_t x;
    x.busy = b; x.done = d; x.ld_data = l; x.ld_key = l; x.round_en = r;
    x.idx = i; x.sh = s; x.dir = k; x.last = la; x.out_en = o;
    return x;
  endfunction

  function automatic outs_t samp0();
    return '{bus.busy, bus.done, bus.ld_data, bus.ld_key, bus.round_en, bus.round_idx,
             bus.key_shift, bus.key_dir, bus.last_round, bus.out_en};
  endfunction

  function automatic outs_t samp1();
    return '{bus1.busy, bus1.done, bus1.ld_data, bus1.ld_key, bus1.round_en, bus1.round_idx,
             bus1.key_shift, bus1.key_dir, bus1.last_round, bus1.out_en};
  endfunction

  task automatic check(input string name, input int n, input outs_t act, input outs_t exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic add_idle();
    vec_t v;
    v.start = 1'b0; v.dec = 1'b0; v.exp = mk(0,0,0,0,0,0,prev_dir,0,0);
    vq.push_back(v);
  endtask

  // One 20-cycle operation, cycle 0 = start-sampling cycle; noise re-pulses start and flips decrypt.
  task automatic add_op(input bit dec, input bit hold, input bit noise);
    vec_t v;
    for (int c = 0; c < 20; c++) begin
      v.start = (c == 0) || hold || (noise && (c == 5 || c == 19));
      v.dec   = (noise && c >= 10) ? ~dec : dec;
      if (c == 0)       v.exp = mk(0,0,0,0,0,0,prev_dir,0,0);
      else if (c == 1)  v.exp = mk(1,0,1,0,0,0,dec,0,0);
      else if (c <= 17) v.exp = mk(1,0,0,1,4'(c-2), dec ? DEC_SH[c-2] : ENC_SH[c-2], dec, c == 17, 0);
      else if (c == 18) v.exp = mk(1,0,0,0,0,0,dec,0,1);
      else              v.exp = mk(0,1,0,0,0,0,dec,0,0);
      vq.push_back(v);
    end
    prev_dir = dec;
  endtask

  task automatic run_table(input string name);
    foreach (vq[i]) begin
      @(negedge clk);
      check(name, i, samp0(), vq[i].exp);
      bus.start   = vq[i].start;
      bus.decrypt = vq[i].dec;
    end
    vq.delete();
  endtask

  initial begin
    outs_t one_exp [6];
    rst_n = 1'b0;
    bus.start = 1'b0; bus.decrypt = 1'b0;
    bus1.start = 1'b0; bus1.decrypt = 1'b0;
`ifdef DES_ROUND_CTRL_ABORT_EN
    bus.abort = 1'b0;
    bus1.abort = 1'b0;
`endif
    prev_dir = 1'b0;
    #12;
    check("reset0", 0, samp0(), mk(0,0,0,0,0,0,0,0,0));
    check("reset1", 0, samp1(), mk(0,0,0,0,0,0,0,0,0));
    @(posedge clk); #2 rst_n = 1'b1;

    // encrypt, noisy decrypt, held-start back-to-back
    add_op(0, 0, 0);
    add_op(1, 0, 1);
    add_idle();
    add_op(0, 1, 0);
    add_op(1, 0, 0);
    add_idle();
    run_table("main");

    // reset mid-operation at round_idx 7
    @(negedge clk); bus.start = 1'b1; bus.decrypt = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); bus.start = 1'b0;
    end
    check("pre_rst", 9, samp0(), mk(1,0,0,1,7,2,1,0,0));
    rst_n = 1'b0;
    #1 check("mid_rst", 9, samp0(), mk(0,0,0,0,0,0,0,0,0));
    @(posedge clk); #2 rst_n = 1'b1;
    prev_dir = 1'b0;
    add_op(0, 0, 0);
    add_idle();
    run_table("post_rst");

`ifdef DES_ROUND_CTRL_ABORT_EN
    @(negedge clk); bus.start = 1'b1; bus.decrypt = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); bus.start = 1'b0;
    end
    check("pre_abort", 6, samp0(), mk(1,0,0,1,4,2,0,0,0));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort", 7, samp0(), mk(0,0,0,0,0,0,0,0,0));
    for (int c = 8; c <= 24; c++) begin
      @(negedge clk);
      check("abort_idle", c, samp0(), mk(0,0,0,0,0,0,0,0,0));
    end
    prev_dir = 1'b0;
    add_op(0, 0, 0);
    add_idle();
    run_table("post_abort");
`endif

    // single-round instance
    one_exp[0] = mk(0,0,0,0,0,0,0,0,0);
    one_exp[1] = mk(1,0,1,0,0,0,0,0,0);
    one_exp[2] = mk(1,0,0,1,0,1,0,1,0);
    one_exp[3] = mk(1,0,0,0,0,0,0,0,1);
    one_exp[4] = mk(0,1,0,0,0,0,0,0,0);
    one_exp[5] = mk(0,0,0,0,0,0,0,0,0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("nr1", c, samp1(), one_exp[c]);
      bus1.start = (c == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16: number of Feistel rounds sequenced; legal range 1..16.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1: request one block operation; sampled in IDLE only.
REQ-005 SHALL have port decrypt  input  1: 0 = encrypt, 1 = decrypt; sampled with accepted start.
REQ-006 SHALL have port busy  output  1: high from the cycle after accepted start through the FINAL state.
REQ-007 SHALL have port done  output  1: single-cycle completion pulse.
REQ-008 SHALL have port ld_data  output  1: datapath loads L/R from the initial permutation.
REQ-009 SHALL have port ld_key  output  1: key schedule loads C/D from PC-1.
REQ-010 SHALL have port round_en  output  1: datapath captures next L/R (expansion, S-box and P result).
REQ-011 SHALL have port round_idx  output  4: current round, 0-based.
REQ-012 SHALL have port key_shift  output  2: C/D rotate amount (0, 1 or 2) for the current round.
REQ-013 SHALL have port key_dir  output  1: 0 = rotate left (encrypt), 1 = rotate right (decrypt).
REQ-014 SHALL have port last_round  output  1: high with round_en on the final round; the datapath suppresses the L/R swap on that round.
REQ-015 SHALL have port out_en  output  1: capture the final-permutation result into the output register.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, ROUND, FINAL and DONE.
REQ-017 SHALL take these transitions: IDLE->LOAD on start; LOAD->ROUND unconditionally; ROUND->FINAL when round_idx==NUM_ROUNDS-1; otherwise stay in ROUND with round_idx+1; FINAL->DONE; DONE->IDLE.
REQ-018 SHALL assert ld_data and ld_key together for exactly the one LOAD cycle.
REQ-019 SHALL assert round_en in every ROUND cycle, with round_idx counting 0..NUM_ROUNDS-1, one per cycle.
REQ-020 SHALL, when encrypting, set key_shift per round_idx 0..15 to 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 SHALL, when decrypting, set key_shift per round_idx 0..15 to 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-022 SHALL drive key_dir as the registered decrypt value; it stays stable from LOAD through DONE.
REQ-023 SHALL assert out_en for exactly the one FINAL cycle and done for exactly the one DONE cycle.
REQ-024 SHALL drive busy, key_shift, round_idx and last_round to 0 outside LOAD, ROUND and FINAL.
REQ-025 SHALL give a latency of NUM_ROUNDS+3 cycles from the start-sampling edge to done high (19 for the default).
REQ-026 SHALL ignore start while in any state other than IDLE (no queuing); start held high SHALL begin a new block the cycle after DONE.
REQ-027 SHALL ignore changes on decrypt during an operation.
REQ-028 SHALL never have more than one of ld_data, round_en, out_en and done high in the same cycle.

Reset
REQ-029 SHALL, on rst_n low, immediately force IDLE, round_idx=0, the registered decrypt bit=0 and all outputs=0, including mid-operation.
REQ-030 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, when macro DES_ROUND_CTRL_ABORT_EN is defined, add input abort (1 bit): abort high in LOAD, ROUND or FINAL forces IDLE on the next edge without done or out_en, and abort has no effect in IDLE or DONE.
REQ-032 SHALL, when DES_ROUND_CTRL_ABORT_EN is undefined, have no abort port; every accepted start completes with done.

Verification
REQ-033 Encrypt with default NUM_ROUNDS, start pulse at cycle 0 -> ld_data/ld_key at cycle 1; round_en at cycles 2..17 with key_shift 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; last_round at cycle 17; out_en at cycle 18; done at cycle 19.
REQ-034 Decrypt -> key_dir=1 from cycle 1 to cycle 19; key_shift 0 at round_idx 0 and 1 at round_idx 1, 8 and 15.
REQ-035 Start re-pulsed at cycles 5 and 19 of a running block, and decrypt toggled at cycle 10 -> no restart, schedule unchanged, done only at cycle 19.
REQ-036 rst_n low at cycle 9 (round_idx 7) -> all outputs 0 immediately; start at the next enabled cycle -> full 19-cycle operation.
REQ-037 NUM_ROUNDS=1 -> round_en and last_round at cycle 2 only; done at cycle 4.
REQ-038 With DES_ROUND_CTRL_ABORT_EN, abort at round_idx 4 -> IDLE on the next edge, no out_en, no done; a new start is then accepted.
